// File: rtl/pipeline_reg_if_id.sv
// rtl/pipeline_reg_if_id.sv - IF/ID pipeline register with stall hold and flush bubble (optional pc_plus4_out under IFID_PC4_EN)
module pipeline_reg_if_id #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            stall,
  input  logic [XLEN-1:0] instr_in,
  input  logic [XLEN-1:0] pc_in,
  output logic [XLEN-1:0] instr_out,
  output logic [XLEN-1:0] pc_out,
  output logic            valid_out
`ifdef IFID_PC4_EN
  ,
  output logic [XLEN-1:0] pc_plus4_out
`endif
);

  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;
`ifdef IFID_PC4_EN
  logic [XLEN-1:0] pc4_q, pc4_d;
`endif

  // Next-slot selection: flush beats stall, stall holds, otherwise capture.
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
`ifdef IFID_PC4_EN
    pc4_d   = pc4_q;
`endif
    if (flush) begin
      instr_d = NOP_INSTR;
      pc_d    = '0;
      valid_d = 1'b0;
`ifdef IFID_PC4_EN
      pc4_d   = '0;
`endif
    end else if (!stall) begin
      instr_d = instr_in;
      pc_d    = pc_in;
      valid_d = 1'b1;
`ifdef IFID_PC4_EN
      pc4_d   = pc_in + XLEN'(4);
`endif
    end
  end

  // Slot register; reset loads a bubble immediately without a clock edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
      valid_q <= 1'b0;
`ifdef IFID_PC4_EN
      pc4_q   <= '0;
`endif
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
`ifdef IFID_PC4_EN
      pc4_q   <= pc4_d;
`endif
    end
  end

  assign instr_out = instr_q;
  assign pc_out    = pc_q;
  assign valid_out = valid_q;
`ifdef IFID_PC4_EN
  assign pc_plus4_out = pc4_q;
`endif

endmodule

// File: tb/tb_pipeline_reg_if_id.sv
// tb/tb_pipeline_reg_if_id.sv - randomized self-checking bench for pipeline_reg_if_id
module tb_pipeline_reg_if_id;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] instr_in = '0;
  logic [31:0] pc_in = '0;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        valid_out;
`ifdef IFID_PC4_EN
  logic [31:0] pc_plus4_out;
`endif

  int total = 0;
  int bad = 0;

  // reference slot contents
  logic [31:0] m_instr = NOP;
  logic [31:0] m_pc = '0;
  logic        m_valid = 1'b0;
  logic [31:0] m_pc4 = '0;

  pipeline_reg_if_id dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .stall     (stall),
    .instr_in  (instr_in),
    .pc_in     (pc_in),
    .instr_out (instr_out),
    .pc_out    (pc_out),
    .valid_out (valid_out)
`ifdef IFID_PC4_EN
    ,
    .pc_plus4_out (pc_plus4_out)
`endif
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] wrap_plus4(input logic [31:0] p);
    longint unsigned s;
    s = (longint'(p) + 64'd4) % 64'h1_0000_0000;
    return s[31:0];
  endfunction

  task automatic model_clear();
    m_instr = NOP;
    m_pc    = '0;
    m_valid = 1'b0;
    m_pc4   = '0;
  endtask

  // drive one edge's worth of inputs and advance the reference model
  task automatic apply(input logic f, input logic s, input logic [31:0] i, input logic [31:0] p);
    @(negedge clock);
    flush = f;
    stall = s;
    instr_in = i;
    pc_in = p;
    @(posedge clock);
    if (!reset) model_clear();
    else if (f) model_clear();
    else if (!s) begin
      m_instr = i;
      m_pc    = p;
      m_valid = 1'b1;
      m_pc4   = wrap_plus4(p);
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #10;
    total++; if (instr_out !== NOP) begin bad++; $display("FAIL reset_instr got=%h exp=%h", instr_out, NOP); end
    total++; if (pc_out !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", pc_out); end
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid_out); end
    @(negedge clock);
    reset = 1'b1;
    model_clear();
  endtask

  task automatic test_capture();
    apply(1'b0, 1'b0, 32'h1234_5678, 32'h4);
    total++; if (instr_out !== 32'h1234_5678) begin bad++; $display("FAIL cap_instr got=%h exp=12345678", instr_out); end
    total++; if (pc_out !== 32'h4) begin bad++; $display("FAIL cap_pc got=%h exp=4", pc_out); end
    total++; if (valid_out !== 1'b1) begin bad++; $display("FAIL cap_valid got=%b exp=1", valid_out); end
  endtask

  task automatic test_stall();
    apply(1'b0, 1'b1, 32'hAAAA_AAAA, 32'h8);
    total++; if (instr_out !== 32'h1234_5678 || pc_out !== 32'h4 || valid_out !== 1'b1) begin
      bad++; $display("FAIL stall_hold got=%h/%h/%b exp=12345678/4/1", instr_out, pc_out, valid_out);
    end
    apply(1'b0, 1'b0, 32'hAAAA_AAAA, 32'h8);
    total++; if (instr_out !== 32'hAAAA_AAAA || pc_out !== 32'h8) begin
      bad++; $display("FAIL stall_release got=%h/%h exp=aaaaaaaa/8", instr_out, pc_out);
    end
  endtask

  task automatic test_flush();
    apply(1'b1, 1'b0, 32'hBBBB_BBBB, 32'hC);
    total++; if (instr_out !== NOP || pc_out !== 32'h0 || valid_out !== 1'b0) begin
      bad++; $display("FAIL flush_bubble got=%h/%h/%b exp=00000013/0/0", instr_out, pc_out, valid_out);
    end
    apply(1'b0, 1'b0, 32'hCCCC_CCCC, 32'h10);
    total++; if (instr_out !== 32'hCCCC_CCCC || pc_out !== 32'h10 || valid_out !== 1'b1) begin
      bad++; $display("FAIL flush_after got=%h/%h/%b exp=cccccccc/10/1", instr_out, pc_out, valid_out);
    end
  endtask

  task automatic test_stall_flush();
    apply(1'b1, 1'b1, 32'hDDDD_DDDD, 32'h14);
    total++; if (instr_out !== NOP || pc_out !== 32'h0 || valid_out !== 1'b0) begin
      bad++; $display("FAIL stall_flush got=%h/%h/%b exp=00000013/0/0", instr_out, pc_out, valid_out);
    end
  endtask

  task automatic test_sequence();
    logic [31:0] ins [3];
    logic [31:0] pcs [3];
    ins = '{32'h1, 32'h2, 32'h3};
    pcs = '{32'h0, 32'h4, 32'h8};
    for (int k = 0; k < 3; k++) begin
      apply(1'b0, 1'b0, ins[k], pcs[k]);
      total++; if (instr_out !== ins[k] || pc_out !== pcs[k]) begin
        bad++; $display("FAIL seq_%0d got=%h/%h exp=%h/%h", k, instr_out, pc_out, ins[k], pcs[k]);
      end
    end
`ifdef IFID_PC4_EN
    total++; if (pc_plus4_out !== 32'hC) begin bad++; $display("FAIL seq_pc4 got=%h exp=c", pc_plus4_out); end
    apply(1'b0, 1'b0, 32'h0, 32'hFFFF_FFFC);
    total++; if (pc_plus4_out !== 32'h0) begin bad++; $display("FAIL pc4_wrap got=%h exp=0", pc_plus4_out); end
`endif
  endtask

  task automatic test_async_reset();
    apply(1'b0, 1'b0, 32'h5A5A_1234, 32'h100);
    #2;
    reset = 1'b0;
    #1;
    model_clear();
    total++; if (instr_out !== NOP || pc_out !== 32'h0 || valid_out !== 1'b0) begin
      bad++; $display("FAIL async_reset got=%h/%h/%b exp=00000013/0/0", instr_out, pc_out, valid_out);
    end
    for (int k = 0; k < 4; k++) begin
      apply(1'(k & 1), 1'(k >> 1), $urandom, $urandom);
      total++; if (instr_out !== NOP || pc_out !== 32'h0 || valid_out !== 1'b0) begin
        bad++; $display("FAIL reset_hold_%0d got=%h/%h/%b exp=00000013/0/0", k, instr_out, pc_out, valid_out);
      end
    end
    @(negedge clock);
    reset = 1'b1;
    apply(1'b0, 1'b0, 32'hFEED_0001, 32'h200);
    total++; if (instr_out !== 32'hFEED_0001 || pc_out !== 32'h200 || valid_out !== 1'b1) begin
      bad++; $display("FAIL first_after_reset got=%h/%h/%b exp=feed0001/200/1", instr_out, pc_out, valid_out);
    end
  endtask

  task automatic test_random();
    logic f, s;
    for (int k = 0; k < 300; k++) begin
      f = ($urandom_range(0, 5) == 0);
      s = ($urandom_range(0, 3) == 0);
      apply(f, s, $urandom, $urandom);
      total++; if (instr_out !== m_instr || pc_out !== m_pc || valid_out !== m_valid) begin
        bad++; $display("FAIL rand_%0d got=%h/%h/%b exp=%h/%h/%b", k, instr_out, pc_out, valid_out, m_instr, m_pc, m_valid);
      end
`ifdef IFID_PC4_EN
      total++; if (pc_plus4_out !== m_pc4) begin
        bad++; $display("FAIL rand_pc4_%0d got=%h exp=%h", k, pc_plus4_out, m_pc4);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_stall();
    test_flush();
    test_stall_flush();
    test_sequence();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
